// File: rtl/hazard_tracker.sv
// Tracks in-flight register writes in the EX/MEM/WB slots, derives operand
// forward selects for the ID instruction and raises the load-use stall.
module hazard_tracker #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             advance,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic [REG_W-1:0] ex_dest,
    output logic             ex_regWrite,
    output logic [REG_W-1:0] mem_dest,
    output logic             mem_regWrite,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             wr;
        logic             ld;
    } slot_t;

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic wr_cap;
    logic hit_rs;
    logic hit_rt;
    logic hazard;

    // Youngest producer wins; a load still in EX cannot forward (stall covers it).
    function automatic logic [1:0] fwd_sel(
        input logic             use_op,
        input logic [REG_W-1:0] idx,
        input logic             stl,
        input slot_t            ex,
        input slot_t            mem,
        input slot_t            wb
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_op && (idx != '0) && !stl) begin
            if (ex.v && ex.wr && !ex.ld && (ex.dest == idx))
                sel = 2'd1;
            else if (mem.v && mem.wr && (mem.dest == idx))
                sel = 2'd2;
            else if (wb.v && wb.wr && (wb.dest == idx))
                sel = 2'd3;
        end
        return sel;
    endfunction

    assign wr_cap = id_regWrite && (id_dest != '0);
    assign hit_rs = id_use_rs && (id_rs != '0) && (id_rs == ex_q.dest);
    assign hit_rt = id_use_rt && (id_rt != '0) && (id_rt == ex_q.dest);
    assign hazard = id_valid && ex_q.v && ex_q.wr && ex_q.ld && (hit_rs || hit_rt);
    assign stall  = hazard && !flush;

    assign fwdA_sel     = fwd_sel(id_use_rs, id_rs, stall, ex_q, mem_q, wb_q);
    assign fwdB_sel     = fwd_sel(id_use_rt, id_rt, stall, ex_q, mem_q, wb_q);
    assign ex_dest      = ex_q.dest;
    assign ex_regWrite  = ex_q.v && ex_q.wr;
    assign mem_dest     = mem_q.dest;
    assign mem_regWrite = mem_q.v && mem_q.wr;
    assign stall_cycles = cnt_q;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (advance) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (id_valid && !stall && !flush)
                ex_d = '{v: 1'b1, dest: id_dest, wr: wr_cap, ld: id_memRead && wr_cap};
            else
                ex_d = '0;
            if (stall && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: load-use stall, forwarding priority,
// $0 handling, flush/advance gating, counter saturation and async reset.
module tb_hazard_tracker;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             CLK;
    logic             nRST;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_regWrite;
    logic             id_memRead;
    logic             advance;
    logic             flush;
    logic             stall;
    logic [1:0]       fwdA_sel;
    logic [1:0]       fwdB_sel;
    logic [REG_W-1:0] ex_dest;
    logic             ex_regWrite;
    logic [REG_W-1:0] mem_dest;
    logic             mem_regWrite;
    logic [CNT_W-1:0] stall_cycles;

    int total;
    int bad;

    hazard_tracker #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .advance(advance), .flush(flush),
        .stall(stall), .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
        .ex_dest(ex_dest), .ex_regWrite(ex_regWrite),
        .mem_dest(mem_dest), .mem_regWrite(mem_regWrite),
        .stall_cycles(stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                          input logic urs, input logic urt, input logic [REG_W-1:0] dest,
                          input logic wr, input logic ld);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_dest     = dest;
        id_regWrite = wr;
        id_memRead  = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        nRST    = 1'b0;
        advance = 1'b1;
        flush   = 1'b0;
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
        check("rst_stall", stall, 0);
        check("rst_fwdA", fwdA_sel, 0);
        check("rst_fwdB", fwdB_sel, 0);
        check("rst_exwr", ex_regWrite, 0);
        check("rst_cnt", stall_cycles, 0);
        tick();
        tick();
        nRST = 1'b1;

        // Load-use: lw r8 enters EX, then add r9,r8,r2 stalls one cycle.
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        check("lw_nostall", stall, 0);
        tick();
        check("lw_exdest", ex_dest, 8);
        check("lw_exwr", ex_regWrite, 1);
        set_id(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        check("lu_stall", stall, 1);
        check("lu_fwdA", fwdA_sel, 0);
        check("lu_fwdB", fwdB_sel, 0);
        tick();
        check("lu_stall_after", stall, 0);
        check("lu_fwdA_after", fwdA_sel, 2);
        check("lu_cnt", stall_cycles, 1);
        check("lu_exwr_bubble", ex_regWrite, 0);
        check("lu_memdest", mem_dest, 8);
        check("lu_memwr", mem_regWrite, 1);

        // EX=r9, MEM=bubble, WB=lw r8
        tick();
        set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        check("wb_ld_fwdA", fwdA_sel, 3);
        check("ex_alu_fwdB", fwdB_sel, 1);
        tick();
        set_id(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        check("mem_fwdA", fwdA_sel, 2);
        check("bubble_fwdB", fwdB_sel, 0);
        tick();
        // Youngest wins: r5 in EX and in MEM.
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        check("young_fwdA", fwdA_sel, 1);
        check("young_fwdB", fwdB_sel, 1);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        check("young2_fwdA", fwdA_sel, 2);
        check("young2_fwdB", fwdB_sel, 2);
        check("young2_exdest", ex_dest, 6);
        check("young2_memdest", mem_dest, 5);

        // $0 write captured as non-writing; r0 readers never forward.
        tick();
        check("r0_exwr", ex_regWrite, 0);
        check("r0_exdest", ex_dest, 0);
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        check("r0_fwdA", fwdA_sel, 0);
        check("r0_fwdB", fwdB_sel, 0);
        tick();
        set_id(1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        check("wb_r6_fwdA", fwdA_sel, 3);
        check("ex_r7_fwdB", fwdB_sel, 1);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        check("wb_r7_fwdA", fwdA_sel, 3);
        check("unused_fwdB", fwdB_sel, 0);

        // Flush squashes the load-use stall.
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        check("fl_pre_stall", stall, 1);
        flush = 1'b1;
        #1;
        check("fl_stall", stall, 0);
        check("fl_fwdA_ld_ex", fwdA_sel, 0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_exwr", ex_regWrite, 0);
        check("fl_memdest", mem_dest, 12);
        check("fl_cnt", stall_cycles, 1);

        // advance=0 holds slots and counter even with a live stall.
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd13, 5'd12, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        advance = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("hold_stall", stall, 1);
        check("hold_cnt", stall_cycles, 1);
        check("hold_exdest", ex_dest, 13);
        check("hold_exwr", ex_regWrite, 1);
        check("hold_memwr", mem_regWrite, 0);
        check("hold_fwdB_wb", fwdB_sel, 0);
        advance = 1'b1;
        tick();
        check("adv_cnt", stall_cycles, 2);

        // Drive the counter to one below saturation, then three more stalls.
        for (int i = 0; i < 12; i++) begin
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
            tick();
        end
        check("pre_sat_cnt", stall_cycles, 14);
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
            check("sat_stall", stall, 1);
            tick();
            check("sat_cnt", stall_cycles, 15);
        end

        // Asynchronous reset mid-cycle clears everything at once.
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd14, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd13, 5'd14, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        check("prerst_stall", stall, 1);
        check("prerst_exdest", ex_dest, 14);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_stall", stall, 0);
        check("arst_fwdA", fwdA_sel, 0);
        check("arst_fwdB", fwdB_sel, 0);
        check("arst_exdest", ex_dest, 0);
        check("arst_exwr", ex_regWrite, 0);
        check("arst_memdest", mem_dest, 0);
        check("arst_memwr", mem_regWrite, 0);
        check("arst_cnt", stall_cycles, 0);
        set_id(1'b1, 5'd13, 5'd13, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        nRST = 1'b1;
        #1;
        check("postrst_fwdA", fwdA_sel, 0);
        check("postrst_memwr", mem_regWrite, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
